// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  // Bit-counter width for a given operand width, never narrower than one bit.
  function automatic int sa_count_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_cell.sv
// Single-bit full-adder cell with generate/propagate outputs.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout,
  output logic G,
  output logic P
);

  // Generate/propagate form of the ripple cell.
  always_comb begin
    G    = A & B;
    P    = A ^ B;
    S    = P ^ Cin;
    Cout = G | (P & Cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first, through a
// single FullAdder cell with the carry held in a flop.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a-b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = sa_count_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             cell_s;
  logic             cell_cout;
  logic [WIDTH-1:0] acc_next;

  FullAdder u_cell (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (cell_s),
    .Cout (cell_cout),
    .G    (),
    .P    ()
  );

  // Next-state, shift datapath and result capture.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    count_d  = count_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    acc_next = {cell_s, acc_q[WIDTH-1:1]};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
`ifdef SERIAL_ADDER_SUB_EN
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_sh_d  = b;
          carry_d = cin;
`endif
          acc_d   = '0;
          count_d = '0;
          cmsb_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        acc_d   = acc_next;
        carry_d = cell_cout;
        if (count_q == CNT_PENULT) begin
          cmsb_d = cell_cout;
        end
        if (count_q == CNT_LAST) begin
          sum_d   = acc_next;
          cout_d  = cell_cout;
          ovf_d   = cell_cout ^ cmsb_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    ready = (state_q == IDLE) || (state_q == DONE);
    busy  = (state_q == SHIFT);
    done  = done_q;
    sum   = sum_q;
    cout  = cout_q;
    ovf   = ovf_q;
  end

endmodule
